// File: rtl/universal_tristate_register.sv
// WIDTH-bit universal storage/shift/rotate register with serial taps at both ends,
// active-low clock enable, optional output inversion and 3-state parallel outputs.
module universal_tristate_register #(
  parameter int                 WIDTH      = 8,
  parameter bit                 INVERT_OUT = 1'b0,
  parameter logic [WIDTH-1:0]   RESET_VAL  = '0
) (
  input  logic             cp,
  input  logic             mr_,
  input  logic             ce_,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] d,
  input  logic             dsr,
  input  logic             dsl,
  input  logic             oe_,
  output logic [WIDTH-1:0] o,
  output logic             qs0,
  output logic             qsn
);

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_SHUP   = 3'b001,
    MODE_SHDN   = 3'b010,
    MODE_LOAD   = 3'b011,
    MODE_ROTUP  = 3'b100,
    MODE_ROTDN  = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_INVERT = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // An unknown mode select with the clock enabled poisons the register so the
  // problem is visible downstream instead of silently picking a mode.
  always_comb begin
    q_d = q_q;
    if (!ce_) begin
      case (s)
        MODE_HOLD:   q_d = q_q;
        MODE_SHUP:   q_d = {q_q[WIDTH-2:0], dsr};
        MODE_SHDN:   q_d = {dsl, q_q[WIDTH-1:1]};
        MODE_LOAD:   q_d = d;
        MODE_ROTUP:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROTDN:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_CLEAR:  q_d = RESET_VAL;
        MODE_INVERT: q_d = ~q_q;
        default:     q_d = {WIDTH{1'bx}};
      endcase
    end
  end

  always_ff @(posedge cp) begin
    if (!mr_) begin
      q_q <= RESET_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  // Serial taps bypass inversion and the 3-state driver so stages can be cascaded.
  assign o   = oe_ ? {WIDTH{1'bz}} : (INVERT_OUT ? ~q_q : q_q);
  assign qs0 = q_q[0];
  assign qsn = q_q[WIDTH-1];

endmodule

// File: tb/tb_universal_tristate_register.sv
// Bench for universal_tristate_register: two 8-bit stages cascaded (qsn -> dsr),
// directed vectors feed an expected queue that a negedge monitor drains.
module tb_universal_tristate_register;

  localparam int W = 8;

  // clock / reset block
  logic cp = 1'b0;
  always #5 cp = ~cp;

  logic         mr_, ce_, dsr, dsl, oe_;
  logic [2:0]   s;
  logic [W-1:0] d;
  wire  [W-1:0] o0, o1;
  logic         qs0_0, qsn_0, qs0_1, qsn_1;

  // Low stage: plain outputs, reset to 00. High stage: inverted outputs, reset to 3C.
  universal_tristate_register #(.WIDTH(W), .INVERT_OUT(1'b0), .RESET_VAL(8'h00)) u0 (
    .cp(cp), .mr_(mr_), .ce_(ce_), .s(s), .d(d), .dsr(dsr), .dsl(dsl),
    .oe_(oe_), .o(o0), .qs0(qs0_0), .qsn(qsn_0)
  );

  universal_tristate_register #(.WIDTH(W), .INVERT_OUT(1'b1), .RESET_VAL(8'h3C)) u1 (
    .cp(cp), .mr_(mr_), .ce_(ce_), .s(s), .d(d), .dsr(qsn_0), .dsl(dsl),
    .oe_(oe_), .o(o1), .qs0(qs0_1), .qsn(qsn_1)
  );

  // scoreboard: {o0, o1, qs0_0, qsn_0, qs0_1, qsn_1}
  logic [19:0] exp_q[$];
  string       tag_q[$];
  int          checks   = 0;
  int          failures = 0;

  logic [7:0]  e0_prev = 8'h00;
  logic [7:0]  m1      = 8'h00;
  logic [7:0]  cur;
  logic [15:0] pat;
  logic        b;

  logic [19:0] mon_exp, mon_act;
  string       mon_tag;

  // Handshake: the driver pushes one expected entry per rising edge; the monitor
  // owns the pop and compares on the following falling edge.
  initial begin
    forever begin
      @(negedge cp);
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_tag = tag_q.pop_front();
        mon_act = {o0, o1, qs0_0, qsn_0, qs0_1, qsn_1};
        checks++;
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL %s got=%h expected=%h", mon_tag, mon_act, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, expv);
    end
  endtask

  // Driver: exp0 is the hand-computed low-stage value after the edge; the high
  // stage is tracked through the cascade (its dsr is the low stage's old top bit).
  task automatic step(input string name, input logic mr, input logic ce,
                      input logic [2:0] sel, input logic [7:0] dd,
                      input logic sr, input logic sl, input logic oe,
                      input logic [7:0] exp0);
    logic [7:0] n1;
    mr_ = mr; ce_ = ce; s = sel; d = dd; dsr = sr; dsl = sl; oe_ = oe;
    n1 = m1;
    if (!mr)      n1 = 8'h3C;
    else if (!ce) begin
      case (sel)
        3'b001:  n1 = {m1[6:0], e0_prev[7]};
        3'b010:  n1 = {sl, m1[7:1]};
        3'b011:  n1 = dd;
        3'b100:  n1 = {m1[6:0], m1[7]};
        3'b101:  n1 = {m1[0], m1[7:1]};
        3'b110:  n1 = 8'h3C;
        3'b111:  n1 = ~m1;
        default: n1 = m1;
      endcase
    end
    @(posedge cp);
    m1      = n1;
    e0_prev = exp0;
    exp_q.push_back({(oe ? 8'hzz : exp0), (oe ? 8'hzz : ~n1),
                     exp0[0], exp0[7], n1[0], n1[7]});
    tag_q.push_back(name);
    @(negedge cp);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    mr_ = 1'b1; ce_ = 1'b1; s = 3'b000; d = 8'h00; dsr = 1'b0; dsl = 1'b0; oe_ = 1'b0;
    @(negedge cp);
    #1;

    // reset overrides ce_ and a pending load
    step("reset",        1'b0, 1'b0, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);
    step("load_a5",      1'b1, 1'b0, 3'b011, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5);
    step("oe_off",       1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5);
    step("load_hidden",  1'b1, 1'b0, 3'b011, 8'h81, 1'b0, 1'b0, 1'b1, 8'h81);
    step("oe_on",        1'b1, 1'b1, 3'b000, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81);

    step("shup_1",       1'b1, 1'b0, 3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h02);
    step("shup_2",       1'b1, 1'b0, 3'b001, 8'h00, 1'b0, 1'b0, 1'b0, 8'h04);
    step("shdn_1",       1'b1, 1'b0, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0, 8'h82);

    step("load_81",      1'b1, 1'b0, 3'b011, 8'h81, 1'b0, 1'b0, 1'b0, 8'h81);
    step("rotup_1",      1'b1, 1'b0, 3'b100, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03);
    step("rotdn_1",      1'b1, 1'b0, 3'b101, 8'h00, 1'b0, 1'b1, 1'b0, 8'h81);
    step("rotdn_2",      1'b1, 1'b0, 3'b101, 8'h00, 1'b0, 1'b1, 1'b0, 8'hC0);
    cur = 8'hC0;
    for (int i = 0; i < W; i++) begin
      cur = {cur[6:0], cur[7]};
      step("rot_full",   1'b1, 1'b0, 3'b100, 8'h00, 1'b0, 1'b0, 1'b0, cur);
    end

    step("load_3c",      1'b1, 1'b0, 3'b011, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h3C);
    step("ce_hold",      1'b1, 1'b1, 3'b011, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h3C);
    step("reset_ce_off", 1'b0, 1'b1, 3'b011, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);

    step("load_0f",      1'b1, 1'b0, 3'b011, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h0F);
    step("invert",       1'b1, 1'b0, 3'b111, 8'h00, 1'b0, 1'b0, 1'b0, 8'hF0);
    step("clear",        1'b1, 1'b0, 3'b110, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00);

    // 16-bit cascade: after 16 shift-up edges the pair holds the serial pattern
    step("load_5a",      1'b1, 1'b0, 3'b011, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A);
    pat = 16'hC3A1;
    cur = 8'h5A;
    for (int i = 0; i < 16; i++) begin
      b   = pat[15-i];
      cur = {cur[6:0], b};
      step("cascade",    1'b1, 1'b0, 3'b001, 8'h00, b, 1'b0, 1'b0, cur);
    end
    chk("cascade_lo", o0, 8'hA1);
    chk("cascade_hi", o1, 8'h3C);

    repeat (2) @(negedge cp);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain got=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
